signed_seg_scan: RTL and testbench

SIGNED_SEG_SCAN -- requirements
Module: signed_seg_scan

---
 rtl/signed_seg_scan_if.sv | 15 +
 rtl/signed_seg_scan.sv | 111 +++++++++++
 tb/tb_signed_seg_scan.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/signed_seg_scan_if.sv
// Bus between a value source and the signed seven-segment scanner.
// The master drives value/sign/load; the slave (scanner) drives seg/an/frame.
interface signed_seg_scan_if #(
    parameter int DIGITS = 4
);
    logic                        load;
    logic                        sign;
    logic [4*(DIGITS-1)-1:0]     value;
    logic [6:0]                  seg;
    logic [DIGITS-1:0]           an;
    logic                        frame;

    modport master (output load, sign, value, input seg, an, frame);
    modport slave  (input load, sign, value, output seg, an, frame);
endinterface

// File: rtl/signed_seg_scan.sv
// Multiplexed signed hex display driver: leftmost digit is a minus sign, the rest hex.
// Define LEADING_ZERO_BLANK_EN to blank leading zero hex digits (digit 0 always shown).
module signed_seg_scan #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 16
) (
    input  logic               clk,
    input  logic               reset,
    signed_seg_scan_if.slave   bus
);
    localparam int NW = 4 * (DIGITS - 1);
    localparam int IW = $clog2(DIGITS);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0]     pre_q, pre_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [NW-1:0]     sh_val_q;
    logic              sh_sign_q;
    logic [6:0]        seg_q, seg_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic              frame_q, frame_d;
    logic              wrap;
    logic [3:0]        nib;
`ifdef LEADING_ZERO_BLANK_EN
    logic              lead_zero;
`endif

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1111110;
            4'h1: return 7'b0110000;
            4'h2: return 7'b1101101;
            4'h3: return 7'b1111001;
            4'h4: return 7'b0110011;
            4'h5: return 7'b1011011;
            4'h6: return 7'b1011111;
            4'h7: return 7'b1110000;
            4'h8: return 7'b1111111;
            4'h9: return 7'b1111011;
            4'hA: return 7'b1110111;
            4'hB: return 7'b0011111;
            4'hC: return 7'b1001110;
            4'hD: return 7'b0111101;
            4'hE: return 7'b1001111;
            default: return 7'b1000111;
        endcase
    endfunction

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        wrap  = (pre_q == PW'(PRESCALE - 1));
        pre_d = wrap ? '0 : pre_q + PW'(1);
        idx_d = idx_q;
        if (wrap) begin
            idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
        end

        nib = '0;
`ifdef LEADING_ZERO_BLANK_EN
        lead_zero = 1'b0;
`endif
        for (int k = 0; k < DIGITS - 1; k++) begin
            if (idx_q == IW'(k)) begin
                nib = sh_val_q[4*k +: 4];
`ifdef LEADING_ZERO_BLANK_EN
                lead_zero = (k != 0) && ((sh_val_q >> (4 * k)) == '0);
`endif
            end
        end

        if (idx_q == IW'(DIGITS - 1)) begin
            seg_d = {6'b000000, sh_sign_q};
        end else begin
            seg_d = hex7(nib);
`ifdef LEADING_ZERO_BLANK_EN
            if (lead_zero) seg_d = '0;
`endif
        end

        an_d    = DIGITS'(1) << idx_q;
        // Wrap pulse: entering digit 0 while the outputs still show the sign digit.
        frame_d = (idx_q == '0) && an_q[DIGITS-1];
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q     <= '0;
            idx_q     <= '0;
            sh_val_q  <= '0;
            sh_sign_q <= 1'b0;
            seg_q     <= '0;
            an_q      <= '0;
            frame_q   <= 1'b0;
        end else begin
            pre_q   <= pre_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            frame_q <= frame_d;
            if (bus.load) begin
                sh_val_q  <= bus.value;
                sh_sign_q <= bus.sign;
            end
        end
    end

    assign bus.seg   = seg_q;
    assign bus.an    = an_q;
    assign bus.frame = frame_q;
endmodule

// File: tb/tb_signed_seg_scan.sv
// Scoreboard bench for signed_seg_scan: driver pushes expected outputs, monitor pops and compares.
// Honours LEADING_ZERO_BLANK_EN the same way as the design.
module tb_signed_seg_scan;
    localparam int DIGITS   = 4;
    localparam int PRESCALE = 3;
    localparam int NW       = 4 * (DIGITS - 1);

    localparam logic [6:0] HEX7 [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    typedef struct {
        logic [DIGITS-1:0] an;
        logic [6:0]        seg;
        logic              frame;
        int                cyc;
    } exp_t;

    logic clk;
    logic reset;
    signed_seg_scan_if #(.DIGITS(DIGITS)) bus ();

    signed_seg_scan #(.DIGITS(DIGITS), .PRESCALE(PRESCALE)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    exp_t          sb_q[$];
    int            checks   = 0;
    int            failures = 0;
    int            edges_since_reset = 0;
    logic [NW-1:0] m_val  = '0;
    logic          m_sign = 1'b0;
    int            cyc    = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp, input int at);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, at, got, exp);
        end
    endtask

    // Reference view: what a display position shows for a given value/sign.
    function automatic logic [6:0] model_seg(input int pos, input logic [NW-1:0] v, input logic s);
        logic [3:0] n;
        if (pos == DIGITS - 1) return s ? 7'b0000001 : 7'b0000000;
`ifdef LEADING_ZERO_BLANK_EN
        if (pos >= 1 && (v >> (4 * pos)) == '0) return 7'b0000000;
`endif
        n = v[4*pos +: 4];
        return HEX7[n];
    endfunction

    // Drives one cycle of stimulus and records what the following edge must produce.
    task automatic step(input logic rst, input logic ld, input logic sg, input logic [NW-1:0] val);
        exp_t e;
        int   pos;
        @(negedge clk);
        reset     = rst;
        bus.load  = ld;
        bus.sign  = sg;
        bus.value = val;
        cyc++;
        e.cyc = cyc;
        if (rst) begin
            e.an = '0; e.seg = '0; e.frame = 1'b0;
            edges_since_reset = 0;
            m_val  = '0;
            m_sign = 1'b0;
        end else begin
            edges_since_reset++;
            pos     = ((edges_since_reset - 1) / PRESCALE) % DIGITS;
            e.an    = '0;
            e.an[pos] = 1'b1;
            e.seg   = model_seg(pos, m_val, m_sign);
            e.frame = (edges_since_reset > 1) && ((edges_since_reset - 1) % (PRESCALE * DIGITS) == 0);
            if (ld) begin
                m_val  = val;
                m_sign = sg;
            end
        end
        sb_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("an",    32'(bus.an),    32'(e.an),    e.cyc);
                check("seg",   32'(bus.seg),   32'(e.seg),   e.cyc);
                check("frame", 32'(bus.frame), 32'(e.frame), e.cyc);
            end
        end
    end

    initial begin : driver
        logic [NW-1:0] v;
        int            budget;
        reset = 1'b1; bus.load = 1'b0; bus.sign = 1'b0; bus.value = '0;

        // Reset, then idle through two full scans of zeros.
        repeat (2) step(1'b1, 1'b0, 1'b0, '0);
        repeat (2 * PRESCALE * DIGITS + 2) step(1'b0, 1'b0, 1'b0, '0);

        // Negative 3A5, then a value with leading zeros.
        step(1'b0, 1'b1, 1'b1, 12'h3A5);
        repeat (PRESCALE * DIGITS + 3) step(1'b0, 1'b0, 1'b0, '0);
        step(1'b0, 1'b1, 1'b0, 12'h005);
        repeat (PRESCALE * DIGITS + 3) step(1'b0, 1'b0, 1'b0, '0);

        // Mid-scan reset, then reload timed onto the edge that advances to digit 1.
        repeat (2 * PRESCALE + 1) step(1'b0, 1'b0, 1'b0, '0);
        step(1'b1, 1'b1, 1'b1, 12'hFFF);
        repeat (PRESCALE - 1) step(1'b0, 1'b0, 1'b0, '0);
        step(1'b0, 1'b1, 1'b0, 12'h0C0);
        repeat (PRESCALE * DIGITS + 2) step(1'b0, 1'b0, 1'b0, '0);

        // Randomized traffic biased toward small values and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            v = ($urandom_range(0, 2) == 0) ? NW'($urandom_range(0, 255)) : NW'($urandom);
            step($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0, 1'($urandom), v);
        end

        budget = 0;
        while (sb_q.size() > 0 && budget < 10) begin
            @(posedge clk);
            budget++;
        end
        #2;
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0, cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
